// File: rtl/tuple_sum_sched.sv
// tuple_sum_sched
//   Shared-adder scheduler for the conditional tuple-field add datapath.
//   Three requesters are arbitrated round-robin onto one WIDTH-bit adder.
//   The then/else operands are chosen by the requester's condition bit at
//   grant time. The wrapped sum is returned in a per-channel result slot
//   that has its own valid/ready handshake.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req_valid   in   [2:0]       per-channel request valid
//   req_ready   out  [2:0]       per-channel accept, one-hot or zero (combinational)
//   req_cond    in   [2:0]       1 selects the then operands, 0 the else operands
//   req_a_then  in   [3*OPW-1:0] channel i uses [i*OPW +: OPW]
//   req_a_else  in   [3*OPW-1:0]
//   req_b_then  in   [3*OPW-1:0]
//   req_b_else  in   [3*OPW-1:0]
//   res_valid   out  [2:0]       per-channel result slot full
//   res_data    out  [3*WIDTH-1:0] channel i uses [i*WIDTH +: WIDTH]
//   res_ready   in   [2:0]       per-channel result consumed
//   ops_done    out  [7:0]       completed additions, wrapping
module tuple_sum_sched #(
  parameter int OPW   = 5,
  parameter int WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           req_valid,
  output logic [2:0]           req_ready,
  input  logic [2:0]           req_cond,
  input  logic [3*OPW-1:0]     req_a_then,
  input  logic [3*OPW-1:0]     req_a_else,
  input  logic [3*OPW-1:0]     req_b_then,
  input  logic [3*OPW-1:0]     req_b_else,
  output logic [2:0]           res_valid,
  output logic [3*WIDTH-1:0]   res_data,
  input  logic [2:0]           res_ready,
  output logic [7:0]           ops_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_ptr;
  logic [1:0]           r_gnt;
  logic [OPW-1:0]       r_op_a;
  logic [OPW-1:0]       r_op_b;
  logic [2:0]           r_res_valid;
  logic [3*WIDTH-1:0]   r_res_data;
  logic [7:0]           r_ops_done;

  logic [3:0]           w_elig;
  logic [1:0]           w_cand0;
  logic [1:0]           w_cand1;
  logic [1:0]           w_cand2;
  logic                 w_any;
  logic [1:0]           w_gnt;
  logic                 w_accept;
  logic                 w_complete;
  logic [OPW-1:0]       w_sel_a;
  logic [OPW-1:0]       w_sel_b;
  logic [WIDTH-1:0]     w_sum;

  function automatic logic [1:0] inc_mod3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A slot that still holds an undrained result blocks its channel, so the
  // write into a slot can never coincide with a drain of that same slot.
  // Bit 3 is padding so a 2-bit candidate index is always in range.
  assign w_elig = {1'b0, req_valid & ~r_res_valid};

  // Round-robin search order: ptr, ptr+1, ptr+2 (mod 3).
  assign w_cand0 = r_ptr;
  assign w_cand1 = inc_mod3(w_cand0);
  assign w_cand2 = inc_mod3(w_cand1);

  always_comb begin
    w_any = 1'b1;
    w_gnt = w_cand0;
    if (w_elig[w_cand0]) begin
      w_gnt = w_cand0;
    end else if (w_elig[w_cand1]) begin
      w_gnt = w_cand1;
    end else if (w_elig[w_cand2]) begin
      w_gnt = w_cand2;
    end else begin
      w_any = 1'b0;
    end
  end

  // Operand mux for the candidate channel; cond is applied here so only
  // the two chosen operands need to be registered.
  always_comb begin
    w_sel_a = req_cond[0] ? req_a_then[0 +: OPW] : req_a_else[0 +: OPW];
    w_sel_b = req_cond[0] ? req_b_then[0 +: OPW] : req_b_else[0 +: OPW];
    case (w_gnt)
      2'd1: begin
        w_sel_a = req_cond[1] ? req_a_then[OPW +: OPW] : req_a_else[OPW +: OPW];
        w_sel_b = req_cond[1] ? req_b_then[OPW +: OPW] : req_b_else[OPW +: OPW];
      end
      2'd2: begin
        w_sel_a = req_cond[2] ? req_a_then[2*OPW +: OPW] : req_a_else[2*OPW +: OPW];
        w_sel_b = req_cond[2] ? req_b_then[2*OPW +: OPW] : req_b_else[2*OPW +: OPW];
      end
      default: ;
    endcase
  end

  // Zero-extend both operands to WIDTH; the carry out is dropped.
  assign w_sum = WIDTH'(r_op_a) + WIDTH'(r_op_b);

  // Next-state and accept logic.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept           = 1'b1;
          req_ready[w_gnt]   = 1'b1;
          w_state_nxt        = S_EXEC;
        end
      end
      S_EXEC: begin
        w_complete  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant capture: operands and pointer are only sampled on the accept edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_accept) begin
      r_ptr  <= inc_mod3(w_gnt);
      r_gnt  <= w_gnt;
      r_op_a <= w_sel_a;
      r_op_b <= w_sel_b;
    end
  end

  // Result slots: drains are independent of the FSM; the write on the
  // completion edge sets the granted slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_res_valid[i] && res_ready[i]) begin
          r_res_valid[i] <= 1'b0;
        end
        if (w_complete && (r_gnt == 2'(i))) begin
          r_res_valid[i]             <= 1'b1;
          r_res_data[i*WIDTH +: WIDTH] <= w_sum;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ops_done <= '0;
    end else if (w_complete) begin
      r_ops_done <= r_ops_done + 8'd1;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign ops_done  = r_ops_done;

endmodule
